fp_wb_arbiter: RTL

//  Collects completed results from N_UNITS FP execution lanes (fadd/fmul/fdiv...) and retires one per cycle

---
 rtl/fp_wb_pkg.sv | 36 +++
 rtl/fp_wb_rr_arbiter.sv | 28 ++
 rtl/fp_wb_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fp_wb_pkg.sv
// Shared types and constants for the FP writeback arbiter: entry payload, flag widths and bit positions.
package fp_wb_pkg;

  localparam int unsigned FFLAGS_W      = 5;
  localparam int unsigned FP_XLEN       = 32;
  localparam int unsigned FP_TOTAL_REGS = 32;
  localparam int unsigned FP_AW         = $clog2(FP_TOTAL_REGS);

  // fcsr.fflags bit positions
  localparam int unsigned FFLAG_NX = 0;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_NV = 4;

  typedef struct packed {
    logic [FP_AW-1:0]    rd;
    logic [FP_XLEN-1:0]  data;
    logic [FFLAGS_W-1:0] fflags;
  } fp_wb_entry_t;

  // Assemble an fflags vector from individual exception bits.
  function automatic logic [FFLAGS_W-1:0] fflags_make(input logic nv, input logic dz,
                                                      input logic ovf, input logic uf,
                                                      input logic nx);
    logic [FFLAGS_W-1:0] f;
    f = '0;
    f[FFLAG_NV] = nv;
    f[FFLAG_DZ] = dz;
    f[FFLAG_OF] = ovf;
    f[FFLAG_UF] = uf;
    f[FFLAG_NX] = nx;
    return f;
  endfunction

endpackage

// File: rtl/fp_wb_rr_arbiter.sv
// N-way rotating-priority arbiter: the first requester at or after ptr (wrapping) receives a one-hot grant.
module fp_wb_rr_arbiter #(
  parameter  int unsigned N  = 3,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_c
);

  logic found_c;

  always_comb begin
    int unsigned idx;
    grant_c = '0;
    found_c = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found_c && req[PW'(idx)]) begin
        grant_c[PW'(idx)] = 1'b1;
        found_c           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP writeback arbiter: per-lane 1-entry buffers, WAW age ordering, round-robin retire into the FP regfile.
// Optional sticky fflags accumulator enabled by defining FP_WB_FFLAGS_ACC_EN.
module fp_wb_arbiter
  import fp_wb_pkg::*;
#(
  parameter  int unsigned N_UNITS    = 3,
  parameter  int unsigned XLEN       = FP_XLEN,
  parameter  int unsigned TOTAL_REGS = FP_TOTAL_REGS,
  localparam int unsigned AW         = $clog2(TOTAL_REGS),
  localparam int unsigned PW         = $clog2(N_UNITS)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [N_UNITS-1:0]                lane_valid_i,
  output logic [N_UNITS-1:0]                lane_ready_o,
  input  logic [N_UNITS-1:0][AW-1:0]        lane_rd_i,
  input  logic [N_UNITS-1:0][XLEN-1:0]      lane_data_i,
  input  logic [N_UNITS-1:0][FFLAGS_W-1:0]  lane_fflags_i,
  output logic                              FP_reg_write_p_mux,
  output logic [AW-1:0]                     waddr_wb,
  output logic [XLEN-1:0]                   wdata_wb,
  output logic [FFLAGS_W-1:0]               fflags_wb,
  output logic [N_UNITS-1:0][AW-1:0]        pending_rd_o,
  output logic [N_UNITS-1:0]                pending_valid_o
`ifdef FP_WB_FFLAGS_ACC_EN
  ,
  input  logic                              fflags_clr_i,
  output logic [FFLAGS_W-1:0]               fflags_acc_o
`endif
);

  fp_wb_entry_t       ent_q [N_UNITS];
  logic [N_UNITS-1:0] ent_v_q;
  // age_q[i][j] set means entry j is older than entry i
  logic [N_UNITS-1:0] age_q [N_UNITS];
  logic [PW-1:0]      rr_ptr_q;

  logic [N_UNITS-1:0] cap_c;
  logic [N_UNITS-1:0] elig_c;
  logic [N_UNITS-1:0] grant_c;
  logic               any_grant_c;
  logic [PW-1:0]      gnt_idx_c;
  fp_wb_entry_t       sel_c;

  // A draining buffer can refill in the same cycle.
  assign lane_ready_o = ~ent_v_q | grant_c;
  assign cap_c        = lane_valid_i & lane_ready_o;
  assign any_grant_c  = |grant_c;

  always_comb begin
    for (int i = 0; i < N_UNITS; i++) begin
      pending_rd_o[i] = ent_q[i].rd;
    end
    pending_valid_o = ent_v_q;
  end

  // An entry may retire only when no older buffered entry targets the same rd.
  always_comb begin
    elig_c = ent_v_q;
    for (int i = 0; i < N_UNITS; i++) begin
      for (int j = 0; j < N_UNITS; j++) begin
        if (age_q[i][j] && ent_v_q[j] && (ent_q[j].rd == ent_q[i].rd)) elig_c[i] = 1'b0;
      end
    end
  end

  fp_wb_rr_arbiter #(.N(N_UNITS)) u_rr (
    .req     (elig_c),
    .ptr     (rr_ptr_q),
    .grant_c (grant_c)
  );

  always_comb begin
    sel_c     = '0;
    gnt_idx_c = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (grant_c[i]) begin
        sel_c     = ent_q[i];
        gnt_idx_c = PW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_v_q <= '0;
      for (int i = 0; i < N_UNITS; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_UNITS; i++) begin
        if (cap_c[i]) begin
          ent_v_q[i]      <= 1'b1;
          ent_q[i].rd     <= lane_rd_i[i];
          ent_q[i].data   <= lane_data_i[i];
          ent_q[i].fflags <= lane_fflags_i[i];
        end else if (grant_c[i]) begin
          ent_v_q[i] <= 1'b0;
        end
      end
    end
  end

  // New entries are younger than every surviving entry; same-cycle captures order by lane index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_UNITS; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_UNITS; i++) begin
        for (int j = 0; j < N_UNITS; j++) begin
          if (cap_c[i]) begin
            age_q[i][j] <= (ent_v_q[j] & ~grant_c[j]) | (cap_c[j] & (j < i));
          end else if (cap_c[j]) begin
            age_q[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else if (any_grant_c) begin
      rr_ptr_q <= (gnt_idx_c == PW'(N_UNITS - 1)) ? '0 : gnt_idx_c + PW'(1);
    end
  end

  // Write port register; data holds when nothing retires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      FP_reg_write_p_mux <= 1'b0;
      waddr_wb           <= '0;
      wdata_wb           <= '0;
      fflags_wb          <= '0;
    end else begin
      FP_reg_write_p_mux <= any_grant_c;
      if (any_grant_c) begin
        waddr_wb  <= sel_c.rd;
        wdata_wb  <= sel_c.data;
        fflags_wb <= sel_c.fflags;
      end
    end
  end

`ifdef FP_WB_FFLAGS_ACC_EN
  // Clear takes priority and drops any flags retiring in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fflags_acc_o <= '0;
    end else if (fflags_clr_i) begin
      fflags_acc_o <= '0;
    end else if (any_grant_c) begin
      fflags_acc_o <= fflags_acc_o | sel_c.fflags;
    end
  end
`endif

endmodule
